// File: rtl/boton_pulsacion_pkg.sv
// Shared definitions for the button press classifier: state encodings and
// the press-length thresholds used in hardware and in simulation.
package boton_pulsacion_pkg;

    typedef enum logic [1:0] {
        ST_BLOQ  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PRESS = 2'd2,
        ST_HELD  = 2'd3
    } estado_t;

    // 5 s at 50 MHz
    localparam int LONG_CYCLES_DEF = 250000000;
    // Short threshold so benches can reach the long-press path quickly
    localparam int LONG_CYCLES_SIM = 8;

endpackage

// File: rtl/boton_pulsacion.sv
// Classifies each debounced button press as short or long, emitting one-cycle
// event pulses plus a level that stays high while a long press is held.
module boton_pulsacion
    import boton_pulsacion_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int CNT_W       = $clog2(LONG_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic mantenido
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

    estado_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             corto_reg, corto_next;
    logic             largo_reg, largo_next;
    logic             mant_reg, mant_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_BLOQ;
            cnt_reg   <= '0;
            corto_reg <= 1'b0;
            largo_reg <= 1'b0;
            mant_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            corto_reg <= corto_next;
            largo_reg <= largo_next;
            mant_reg  <= mant_next;
        end
    end

    // cnt holds the number of high samples seen so far in the current press;
    // it stops advancing once HELD is reached, so long holds cannot wrap it.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        corto_next = 1'b0;
        largo_next = 1'b0;
        mant_next  = 1'b0;
        case (state_reg)
            ST_BLOQ: begin
                cnt_next = '0;
                if (!boton_in) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (boton_in) begin
                    state_next = ST_PRESS;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_PRESS: begin
                if (!boton_in) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    corto_next = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_HELD;
                    largo_next = 1'b1;
                    mant_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (boton_in) begin
                    mant_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_BLOQ;
                cnt_next   = '0;
            end
        endcase
    end

    assign pulso_corto = corto_reg;
    assign pulso_largo = largo_reg;
    assign mantenido   = mant_reg;

endmodule
